// File: rtl/op_sel_seq.sv
// Button-driven 3-bit pattern select: two debounced step buttons plus load/hold.
// Each button is synchronized, debounced, and edge-detected into a one-edge step.

module op_sel_seq_db #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);
  localparam logic [7:0] LP_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       r_s1, r_s2, r_lvl;
  logic [7:0] r_cnt;
  logic       w_diff, w_accept;

  assign w_diff   = r_s2 ^ r_lvl;
  // Accept on the edge that would complete DEBOUNCE_CYCLES differing samples.
  assign w_accept = w_diff && (r_cnt == LP_LAST);
  assign o_rise   = w_accept && r_s2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_lvl <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_lvl <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end
endmodule

module op_sel_seq #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       hold,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       sel_chg
);
  localparam int NUM_BTN = 2;

  logic [NUM_BTN-1:0] w_btn, w_rise;
  logic [2:0]         r_sel, w_nxt;
  logic               r_chg;

  assign w_btn = {btn_down, btn_up};

  generate
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      op_sel_seq_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_btn  (w_btn[g]),
        .o_rise (w_rise[g])
      );
    end
  endgenerate

  // load beats hold beats step; simultaneous up/down fall into default and cancel.
  always_comb begin
    w_nxt = r_sel;
    if (load) begin
      w_nxt = load_val;
    end else if (!hold) begin
      case (w_rise)
        2'b01:   w_nxt = r_sel + 3'd1;
        2'b10:   w_nxt = r_sel - 3'd1;
        default: w_nxt = r_sel;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= '0;
      r_chg <= 1'b0;
    end else begin
      r_sel <= w_nxt;
      r_chg <= (w_nxt != r_sel);
    end
  end

  assign {S2, S1, S0} = r_sel;
  assign sel_chg      = r_chg;
endmodule

// File: tb/tb_op_sel_seq.sv
// Bench for op_sel_seq: directed scenarios plus random traffic, checked every
// cycle against a sample-history reference model.

module tb_op_sel_seq;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, load = 1'b0, hold = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic       S0, S1, S2, sel_chg;

  int    n_tests = 0, n_fail = 0;
  string phase = "reset";

  op_sel_seq #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .load(load), .load_val(load_val), .hold(hold),
    .S0(S0), .S1(S1), .S2(S2), .sel_chg(sel_chg)
  );

  always #5 clk = ~clk;

  // Reference state: select as an integer, per-button accepted level and run length.
  int m_sel, m_chg;
  bit m_lvl[2];
  int m_run[2];
  bit hist_up[$];
  bit hist_dn[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d", phase, tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_sel = 0;
    m_chg = 0;
    for (int b = 0; b < 2; b++) begin
      m_lvl[b] = 1'b0;
      m_run[b] = 0;
    end
    hist_up.delete();
    hist_dn.delete();
  endtask

  // Input level the debouncer compares at this edge: the sample from two edges ago.
  function automatic bit past2(input bit q[$]);
    return (q.size() >= 2) ? q[q.size()-2] : 1'b0;
  endfunction

  task automatic deb(input int b, input bit d, output bit ev);
    ev = 1'b0;
    if (d != m_lvl[b]) begin
      m_run[b]++;
      if (m_run[b] == D) begin
        m_lvl[b] = d;
        m_run[b] = 0;
        ev = d;
      end
    end else begin
      m_run[b] = 0;
    end
  endtask

  task automatic m_edge();
    bit d_up, d_dn, e_up, e_dn;
    int nsel;
    if (rst) begin
      m_reset();
      return;
    end
    d_up = past2(hist_up);
    d_dn = past2(hist_dn);
    hist_up.push_back(btn_up);
    hist_dn.push_back(btn_down);
    if (hist_up.size() > 4) void'(hist_up.pop_front());
    if (hist_dn.size() > 4) void'(hist_dn.pop_front());
    deb(0, d_up, e_up);
    deb(1, d_dn, e_dn);
    if (load)      nsel = int'(load_val);
    else if (hold) nsel = m_sel;
    else           nsel = (m_sel + 8 + int'(e_up) - int'(e_dn)) % 8;
    m_chg = (nsel != m_sel) ? 1 : 0;
    m_sel = nsel;
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      m_edge();
      #1;
      chk("sel", {29'd0, S2, S1, S0}, m_sel);
      chk("chg", sel_chg, m_chg);
    end
  endtask

  initial begin
    m_reset();
    #2;
    chk("rst_sel", {29'd0, S2, S1, S0}, 0);
    chk("rst_chg", sel_chg, 0);
    cyc(2);
    rst = 1'b0;
    cyc(3);

    phase = "hold20";
    btn_up = 1'b1;
    cyc(5);
    chk("pre", {29'd0, S2, S1, S0}, 0);
    cyc(1);
    chk("step", {29'd0, S2, S1, S0}, 1);
    chk("pulse", sel_chg, 1);
    cyc(14);
    chk("norepeat", {29'd0, S2, S1, S0}, 1);
    btn_up = 1'b0;
    cyc(8);

    phase = "wrap";
    load = 1'b1; load_val = 3'd7;
    cyc(1);
    load = 1'b0;
    btn_up = 1'b1;   cyc(8); btn_up = 1'b0;   cyc(8);
    chk("up7to0", {29'd0, S2, S1, S0}, 0);
    btn_down = 1'b1; cyc(8); btn_down = 1'b0; cyc(8);
    chk("dn0to7", {29'd0, S2, S1, S0}, 7);

    phase = "glitch";
    btn_up = 1'b1; cyc(3); btn_up = 1'b0; cyc(8);
    chk("short", {29'd0, S2, S1, S0}, 7);
    phase = "cancel";
    btn_up = 1'b1; btn_down = 1'b1; cyc(8);
    chk("both", {29'd0, S2, S1, S0}, 7);
    btn_up = 1'b0; btn_down = 1'b0; cyc(8);

    phase = "hold";
    hold = 1'b1;
    btn_up = 1'b1; cyc(8); btn_up = 1'b0; cyc(8);
    chk("blocked", {29'd0, S2, S1, S0}, 7);
    load = 1'b1; load_val = 3'd5;
    cyc(1);
    chk("load5", {29'd0, S2, S1, S0}, 5);
    chk("load5_chg", sel_chg, 1);
    cyc(1);
    chk("reload_chg", sel_chg, 0);
    load = 1'b0; hold = 1'b0;
    cyc(2);

    phase = "rst_mid";
    btn_up = 1'b1; cyc(4);
    rst = 1'b1; btn_up = 1'b0; m_reset();
    cyc(1);
    rst = 1'b0;
    cyc(10);
    chk("aborted", {29'd0, S2, S1, S0}, 0);

    phase = "async_rst";
    load = 1'b1; load_val = 3'd6;
    cyc(1);
    load = 1'b0;
    cyc(1);
    chk("at6", {29'd0, S2, S1, S0}, 6);
    #3;
    rst = 1'b1;
    m_reset();
    #1;
    chk("imm_sel", {29'd0, S2, S1, S0}, 0);
    chk("imm_chg", sel_chg, 0);
    btn_up = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc(5);
    chk("pre", {29'd0, S2, S1, S0}, 0);
    cyc(1);
    chk("step", {29'd0, S2, S1, S0}, 1);
    cyc(10);
    btn_up = 1'b0;
    cyc(8);
    chk("once", {29'd0, S2, S1, S0}, 1);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) btn_up   = ~btn_up;
      if ($urandom_range(0, 15) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 39) == 0) hold     = ~hold;
      load     = ($urandom_range(0, 31) == 0);
      load_val = 3'($urandom);
      cyc(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/op_sel_seq.md
OP_SEL_SEQ -- requirements
Module: op_sel_seq

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive clocks a synchronized button level must differ from its debounced level before it is accepted (legal range 1..255).
REQ-002 The module SHALL have port clk, input, 1, the single system clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, a reset that is asynchronous and active-high.
REQ-004 The module SHALL have port btn_up, input, 1, a raw asynchronous push-button that increments the selection.
REQ-005 The module SHALL have port btn_down, input, 1, a raw asynchronous push-button that decrements the selection.
REQ-006 The module SHALL have port load, input, 1, a synchronous direct-load strobe.
REQ-007 The module SHALL have port load_val, input, 3, the selection value applied on load, with bit 0 mapping to S0.
REQ-008 The module SHALL have port hold, input, 1, a synchronous freeze that blocks button steps.
REQ-009 The module SHALL have ports S0, S1 and S2, output, 1 each, the registered 3-bit select {S2,S1,S0} driven to the downstream 8:1 pattern mux.
REQ-010 The module SHALL have port sel_chg, output, 1, a registered one-cycle pulse marking any change of {S2,S1,S0}.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, so that sync output = input delayed 2 edges.
REQ-012 Per button, a debounce counter SHALL increment while the synchronized level differs from the debounced level, and clear when they are equal.
REQ-013 When the counter reaches DEBOUNCE_CYCLES, the debounced level SHALL take the synchronized value on that edge and the counter SHALL clear; the input is first sampled on edge 1 and the level changes on edge DEBOUNCE_CYCLES+2.
REQ-014 A step event SHALL occur only on a 0->1 transition of a debounced level; release (1->0) and continuous holding SHALL produce no step and no auto-repeat.
REQ-015 The select update SHALL occur on the same edge as the debounced rising transition, so that {S2,S1,S0} changes on edge DEBOUNCE_CYCLES+2 after the press is first sampled.
REQ-016 An up step SHALL increment the select modulo 8, wrapping 7->0.
REQ-017 A down step SHALL decrement the select modulo 8, wrapping 0->7.
REQ-018 Up and down steps occurring on the same edge SHALL cancel, leaving the select unchanged with sel_chg=0.
REQ-019 The priority on each edge SHALL be load > hold > step.
REQ-020 load=1 SHALL set the select to load_val on the next edge, regardless of hold, and any step on that edge SHALL be discarded.
REQ-021 While hold=1 and load=0, step events SHALL be discarded and not queued, while the debouncers continue tracking their inputs.
REQ-022 sel_chg SHALL be 1 for exactly the cycle following an edge that altered the select value; a load of the current value or a cancelled step SHALL give sel_chg=0.
REQ-023 Glitches on a button shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no step.
REQ-024 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-025 While rst=1, S0=S1=S2=0, sel_chg=0, and all synchronizer flops, debounced levels and counters SHALL be 0, asynchronously and independent of clk.
REQ-026 A button held through reset deassertion SHALL be seen as a new press, producing one step DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
REQ-027 Reset asserted mid-debounce or mid-pulse SHALL abort the operation with no step or sel_chg after release unless the input is still high (see REQ-026).

Verification
REQ-028 With DEBOUNCE_CYCLES=4 and the select at 0, holding btn_up high for 20 cycles -> select=1 after edge 6, sel_chg high for one cycle, and no further change.
REQ-029 From select=7, a clean btn_up press -> select=0 with sel_chg=1; then a btn_down press -> select=7.
REQ-030 A btn_up glitch lasting 3 cycles -> no change; btn_up and btn_down pressed on the same cycle -> no change and sel_chg=0.
REQ-031 With hold=1, a btn_up press -> no change; with hold=1 and load=1, load_val=5 -> select=5 next edge with sel_chg=1; load_val=5 again -> sel_chg=0.
REQ-032 rst pulsed asynchronously between clock edges at select=6 -> outputs 0 immediately; btn_up held across release -> exactly one step, giving select=1.
